// File: rtl/collision_arbiter.sv
// Round-robin arbiter sharing one maze collision-lookup port between NUM_REQ movers.
// One query in flight; each lookup is bounded by TIMEOUT cycles after the port accepts it.
module collision_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned COORD_W = 9,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*COORD_W-1:0] req_x_i,
    input  logic [NUM_REQ*COORD_W-1:0] req_y_i,
    input  logic [NUM_REQ*4-1:0]       req_dir_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [NUM_REQ-1:0]         resp_valid_o,
    output logic                       resp_collide_o,
    output logic                       q_valid_o,
    output logic [COORD_W-1:0]         q_x_o,
    output logic [COORD_W-1:0]         q_y_o,
    output logic [3:0]                 q_dir_o,
    input  logic                       q_ready_i,
    input  logic                       r_valid_i,
    input  logic                       r_collide_i,
    output logic                       timeout_err_o
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [IdxW-1:0]      owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic                 resp_collide_q, resp_collide_d;
    logic                 collide_q, collide_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [3:0]           dir_q, dir_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 win_found;
    logic [IdxW-1:0]      win_idx;
    logic [3:0]           win_dir;

    function automatic logic is_onehot(input logic [3:0] d);
        return (d != 4'b0000) && ((d & (d - 4'b0001)) == 4'b0000);
    endfunction

    // First requester after the last owner wins.
    always_comb begin : p_arb
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(ptr_q) + off) % NUM_REQ;
            if (!win_found && req_i[idx[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[IdxW-1:0];
            end
        end
    end

    assign win_dir = req_dir_i[32'(win_idx)*4 +: 4];

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        grant_d        = '0;
        resp_valid_d   = '0;
        resp_collide_d = 1'b0;
        collide_d      = collide_q;
        x_d            = x_q;
        y_d            = y_q;
        dir_d          = dir_q;
        cnt_d          = cnt_q;
        timeout_err_d  = timeout_err_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    owner_d          = win_idx;
                    ptr_d            = win_idx;
                    grant_d[win_idx] = 1'b1;
                    x_d              = req_x_i[32'(win_idx)*COORD_W +: COORD_W];
                    y_d              = req_y_i[32'(win_idx)*COORD_W +: COORD_W];
                    dir_d            = win_dir;
                    // Malformed direction blocks movement without touching the lookup port.
                    if (is_onehot(win_dir)) begin
                        state_d = StIssue;
                    end else begin
                        collide_d = 1'b1;
                        state_d   = StResp;
                    end
                end
            end
            StIssue: begin
                if (q_ready_i) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (r_valid_i) begin
                    collide_d = r_collide_i;
                    state_d   = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    collide_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                resp_valid_d[owner_q] = 1'b1;
                resp_collide_d        = collide_q;
                state_d               = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            ptr_q          <= IdxW'(NUM_REQ - 1);
            owner_q        <= '0;
            grant_q        <= '0;
            resp_valid_q   <= '0;
            resp_collide_q <= 1'b0;
            collide_q      <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            dir_q          <= '0;
            cnt_q          <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            grant_q        <= grant_d;
            resp_valid_q   <= resp_valid_d;
            resp_collide_q <= resp_collide_d;
            collide_q      <= collide_d;
            x_q            <= x_d;
            y_q            <= y_d;
            dir_q          <= dir_d;
            cnt_q          <= cnt_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign grant_o        = grant_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_collide_o = resp_collide_q;
    assign q_valid_o      = (state_q == StIssue);
    assign q_x_o          = x_q;
    assign q_y_o          = y_q;
    assign q_dir_o        = dir_q;
    assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench for collision_arbiter: a transaction-level timing model predicts every output
// per cycle; a responder process plays the collision unit (collides when the queried x is odd).
module tb_collision_arbiter;

    localparam int NR    = 4;
    localparam int CW    = 9;
    localparam int TO    = 16;
    localparam int DEPTH = 1024;
    localparam int INF   = 1 << 30;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NR-1:0]     req_i;
    logic [NR*CW-1:0]  req_x_i, req_y_i;
    logic [NR*4-1:0]   req_dir_i;
    logic [NR-1:0]     grant_o, resp_valid_o;
    logic              resp_collide_o, q_valid_o, timeout_err_o;
    logic [CW-1:0]     q_x_o, q_y_o;
    logic [3:0]        q_dir_o;
    logic              q_ready_i, r_valid_i, r_collide_i;

    collision_arbiter #(.NUM_REQ(NR), .COORD_W(CW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_x_i(req_x_i), .req_y_i(req_y_i),
        .req_dir_i(req_dir_i), .grant_o(grant_o), .resp_valid_o(resp_valid_o),
        .resp_collide_o(resp_collide_o), .q_valid_o(q_valid_o), .q_x_o(q_x_o), .q_y_o(q_y_o),
        .q_dir_o(q_dir_o), .q_ready_i(q_ready_i), .r_valid_i(r_valid_i),
        .r_collide_i(r_collide_i), .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    endtask

    // Requester operands and collision-unit behaviour knobs.
    logic [CW-1:0] x_tab[NR], y_tab[NR];
    logic [3:0]    dir_tab[NR];
    int m_rdy = 0, m_rk = 1, stray_off = 0, stray_at = -1;

    // Model: expected outputs per cycle.
    logic [NR-1:0] e_grant[DEPTH], e_resp[DEPTH];
    logic          e_coll[DEPTH], e_qv[DEPTH];
    logic [CW-1:0] e_qx[DEPTH], e_qy[DEPTH];
    logic [3:0]    e_qd[DEPTH];
    int m_ptr = NR - 1;
    int terr_from = INF;

    // Observed outputs, recorded for literal checks after each scenario.
    logic [NR-1:0] o_grant[DEPTH], o_resp[DEPTH];
    logic          o_coll[DEPTH], o_qv[DEPTH], o_terr[DEPTH];
    logic [CW-1:0] o_qx[DEPTH];

    task automatic model_reset(input int from);
        for (int i = from; i < DEPTH; i++) begin
            e_grant[i] = '0; e_resp[i] = '0; e_coll[i] = 1'b0; e_qv[i] = 1'b0;
            e_qx[i] = '0; e_qy[i] = '0; e_qd[i] = '0;
        end
        m_ptr     = NR - 1;
        terr_from = INF;
    endtask

    // Requests in mask held from cycle c0; plan ntx transactions; c_end is the last resp cycle.
    task automatic model_run(input int c0, input logic [NR-1:0] mask, input int ntx,
                             output int c_end);
        int t, a, r, own;
        t = c0 + 1;
        r = t;
        for (int n = 0; n < ntx; n++) begin
            own = -1;
            for (int o = 1; o <= NR; o++)
                if (own < 0 && mask[(m_ptr + o) % NR]) own = (m_ptr + o) % NR;
            m_ptr = own;
            e_grant[t] = NR'(1 << own);
            if ($countones(dir_tab[own]) == 1) begin
                a = t + m_rdy;
                for (int i = t; i <= a; i++) begin
                    e_qv[i] = 1'b1; e_qx[i] = x_tab[own]; e_qy[i] = y_tab[own];
                    e_qd[i] = dir_tab[own];
                end
                if (m_rk >= 1 && m_rk <= TO) begin
                    r = a + m_rk + 2;
                    e_coll[r] = x_tab[own][0];
                end else begin
                    r = a + TO + 2;
                    e_coll[r] = 1'b1;
                    if (a + TO + 1 < terr_from) terr_from = a + TO + 1;
                end
            end else begin
                r = t + 1;
                e_coll[r] = 1'b1;
            end
            e_resp[r] = NR'(1 << own);
            t = r + 1;
        end
        c_end = r;
    endtask

    // Compare process: every cycle, every output.
    always @(negedge clk) begin
        if (chk_on && cyc < DEPTH) begin
            o_grant[cyc] = grant_o; o_resp[cyc] = resp_valid_o; o_coll[cyc] = resp_collide_o;
            o_qv[cyc] = q_valid_o; o_qx[cyc] = q_x_o; o_terr[cyc] = timeout_err_o;
            if (rst_i) begin
                chk("rst_flags", {grant_o, resp_valid_o, resp_collide_o, q_valid_o,
                                  timeout_err_o}, 32'd0);
                chk("rst_qops", {q_x_o, q_y_o, q_dir_o}, 32'd0);
            end else begin
                chk("grant", grant_o, e_grant[cyc]);
                chk("resp_valid", resp_valid_o, e_resp[cyc]);
                chk("resp_collide", resp_collide_o, e_coll[cyc]);
                chk("q_valid", q_valid_o, e_qv[cyc]);
                if (e_qv[cyc])
                    chk("q_ops", {q_x_o, q_y_o, q_dir_o}, {e_qx[cyc], e_qy[cyc], e_qd[cyc]});
                chk("timeout_err", timeout_err_o, 32'(cyc >= terr_from));
            end
        end
    end

    // Collision-unit responder.
    initial begin
        int age, acc;
        bit pend, rc;
        age = 0; acc = 0; pend = 0; rc = 0;
        q_ready_i = 1'b0; r_valid_i = 1'b0; r_collide_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                age = 0; pend = 0;
                q_ready_i = 1'b0; r_valid_i = 1'b0;
            end else begin
                age = q_valid_o ? age + 1 : 0;
                q_ready_i = q_valid_o && (age > m_rdy);
                r_valid_i = 1'b0;
                if (pend && m_rk > 0 && cyc == acc + m_rk) begin
                    r_valid_i = 1'b1;
                    pend = 0;
                end
                if (cyc == stray_at) r_valid_i = 1'b1;
                if (q_valid_o && q_ready_i) begin
                    acc = cyc; pend = 1; rc = q_x_o[0];
                end
                r_collide_i = rc;
            end
        end
    end

    task automatic drive_ops();
        for (int i = 0; i < NR; i++) begin
            req_x_i[i*CW +: CW] = x_tab[i];
            req_y_i[i*CW +: CW] = y_tab[i];
            req_dir_i[i*4 +: 4] = dir_tab[i];
        end
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_txns(input logic [NR-1:0] mask, input int ntx, output int c0,
                            output int c_end);
        @(posedge clk); #1;
        c0 = cyc;
        stray_at = (stray_off > 0) ? c0 + stray_off : -1;
        drive_ops();
        req_i = mask;
        model_run(c0, mask, ntx, c_end);
        step_to(c_end);
        req_i = '0;
        step_to(c_end + 2);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1;
        req_i = '0;
        model_reset(cyc);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        int c0, ce, ng;
        logic [NR-1:0] seen;
        logic [NR-1:0] order[5];
        rst_i = 1'b1; req_i = '0; req_x_i = '0; req_y_i = '0; req_dir_i = '0;
        x_tab   = '{9'd200, 9'd37, 9'd311, 9'd96};
        y_tab   = '{9'd230, 9'd5, 9'd400, 9'd77};
        dir_tab = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        order   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        model_reset(0);
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        // 1: single query, answer one cycle after accept.
        m_rdy = 0; m_rk = 1;
        run_txns(4'b0001, 1, c0, ce);
        chk("t1_grant", o_grant[c0+1], 4'b0001);
        chk("t1_qops", {o_qv[c0+1], o_qx[c0+1]}, {1'b1, 9'd200});
        chk("t1_resp", {o_resp[c0+4], o_coll[c0+4]}, {4'b0001, 1'b0});

        // 2: all four requesting, round-robin from requester 0.
        do_reset();
        run_txns(4'b1111, 5, c0, ce);
        ng = 0;
        for (int i = c0; i <= ce; i++) begin
            if (o_grant[i] != '0) begin
                if (ng < 5) chk("t2_order", o_grant[i], order[ng]);
                ng++;
            end
        end
        chk("t2_ngrants", ng, 5);

        // 3: port back-pressure for 5 cycles with a stray r_valid during ISSUE.
        m_rdy = 5; m_rk = 2; stray_off = 3;
        run_txns(4'b0100, 1, c0, ce);
        stray_off = 0;
        for (int i = 1; i <= 6; i++) chk("t3_hold", {o_qv[c0+i], o_qx[c0+i]}, {1'b1, 9'd311});
        chk("t3_resp", {o_resp[c0+10], o_coll[c0+10]}, {4'b0100, 1'b1});

        // 4: no answer -> timeout forces collide and sets the sticky error.
        m_rdy = 0; m_rk = 0;
        run_txns(4'b1000, 1, c0, ce);
        chk("t4_terr_before", o_terr[c0+17], 1'b0);
        chk("t4_terr_set", o_terr[c0+18], 1'b1);
        chk("t4_resp", {o_resp[c0+19], o_coll[c0+19]}, {4'b1000, 1'b1});

        // 5: malformed direction skips the lookup.
        m_rk = 1;
        dir_tab[1] = 4'b0110;
        run_txns(4'b0010, 1, c0, ce);
        chk("t5_grant", {o_grant[c0+1], o_qv[c0+1]}, {4'b0010, 1'b0});
        chk("t5_resp", {o_resp[c0+2], o_coll[c0+2], o_qv[c0+2]}, {4'b0010, 1'b1, 1'b0});
        chk("t4_terr_sticky", o_terr[ce], 1'b1);
        dir_tab[1] = 4'b0100;

        // 6: reset while waiting aborts the query; requester 2 wins afterwards.
        m_rk = 0;
        @(posedge clk); #1;
        c0 = cyc;
        drive_ops();
        req_i = 4'b0010;
        model_run(c0, 4'b0010, 1, ce);
        step_to(c0 + 7);
        do_reset();
        step_to(c0 + 30);
        seen = '0;
        for (int i = c0 + 1; i <= c0 + 30; i++) seen = seen | o_resp[i];
        chk("t6_no_resp", seen, 4'b0000);
        m_rk = 1;
        run_txns(4'b0100, 1, c0, ce);
        chk("t6_grant", o_grant[c0+1], 4'b0100);
        chk("t6_terr_clear", o_terr[ce], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

endmodule
